// File: rtl/perf_counter_reader_pkg.sv
// ---------------------------------------------------------------------------
// perf_counter_reader_pkg
// Shared constants for the performance-counter read side: default bank
// geometry, the counter index map (cycle / instret / event base), the dump
// FSM state encodings and a helper that derives the bank size from the
// number of event counters.
// ---------------------------------------------------------------------------
package perf_counter_reader_pkg;

    // Default bank geometry
    localparam int unsigned PERF_NUM_EVENTS_DEF = 32;
    localparam int unsigned PERF_CNT_W_DEF      = 32;
    localparam int unsigned PERF_IDX_W_DEF      = 6;

    // Counter index map shared with the counter bank and CSR decode
    localparam int unsigned PERF_IDX_CYCLE    = 0;
    localparam int unsigned PERF_IDX_INSTRET  = 1;
    localparam int unsigned PERF_IDX_EVT_BASE = 2;

    // Dump FSM encodings
    localparam logic [0:0] DUMP_IDLE   = 1'b0;
    localparam logic [0:0] DUMP_STREAM = 1'b1;

    // Total addressable counters: cycle + instret + events
    function automatic int unsigned perf_num_cnt(input int unsigned num_events);
        return num_events + PERF_IDX_EVT_BASE;
    endfunction

endpackage : perf_counter_reader_pkg

// File: rtl/perf_cnt_mux.sv
// ---------------------------------------------------------------------------
// perf_cnt_mux
// Combinational index -> counter select over a flattened counter bank.
// Counter k lives at bank[CNT_W*k +: CNT_W]. An index at or beyond NUM_CNT
// returns zero data with err_c set.
// Ports:
//   bank   in  NUM_CNT*CNT_W  flattened counter values
//   idx    in  IDX_W          counter index
//   data_c out CNT_W          selected counter (0 when out of range)
//   err_c  out 1              index out of range
// ---------------------------------------------------------------------------
module perf_cnt_mux
    import perf_counter_reader_pkg::*;
#(
    parameter int unsigned NUM_CNT = perf_num_cnt(PERF_NUM_EVENTS_DEF),
    parameter int unsigned CNT_W   = PERF_CNT_W_DEF,
    parameter int unsigned IDX_W   = PERF_IDX_W_DEF
) (
    input  logic [NUM_CNT*CNT_W-1:0] bank,
    input  logic [IDX_W-1:0]         idx,
    output logic [CNT_W-1:0]         data_c,
    output logic                     err_c
);

    // One-hot compare against every legal index; no match means out of range
    always_comb begin
        data_c = '0;
        err_c  = 1'b1;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (idx == IDX_W'(i)) begin
                data_c = bank[i*CNT_W +: CNT_W];
                err_c  = 1'b0;
            end
        end
    end

endmodule : perf_cnt_mux

// File: rtl/perf_counter_reader.sv
// ---------------------------------------------------------------------------
// perf_counter_reader
// Read-side consumer of the performance counter bank. Serves random-access
// reads (live or snapshot copy) over a valid/ready request/response port and,
// on dump_start, snapshots the whole bank in one cycle and streams every
// counter out over a valid/ready stream. Never modifies the counters.
// Ports:
//   clk, reset                        clock, async active-high reset
//   cycle_count/instret_count         live cycle / retired-instruction counters
//   event_counts                      live event counters, event i at [CNT_W*i +: CNT_W]
//   rd_req_valid/ready/idx/snap       read request (snap=1 reads snapshot copy)
//   rd_rsp_valid/ready/data/err       read response (err: index out of range)
//   dump_start                        pulse: capture bank and start stream
//   dump_busy                         stream in progress
//   out_valid/ready/idx/data/last     snapshot stream beats
// Index map: 0 = cycle, 1 = instret, 2+i = event i.
// ---------------------------------------------------------------------------
module perf_counter_reader
    import perf_counter_reader_pkg::*;
#(
    parameter int unsigned NUM_EVENTS = PERF_NUM_EVENTS_DEF,
    parameter int unsigned CNT_W      = PERF_CNT_W_DEF,
    parameter int unsigned IDX_W      = PERF_IDX_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CNT_W-1:0]            cycle_count,
    input  logic [CNT_W-1:0]            instret_count,
    input  logic [NUM_EVENTS*CNT_W-1:0] event_counts,
    input  logic                        rd_req_valid,
    output logic                        rd_req_ready,
    input  logic [IDX_W-1:0]            rd_req_idx,
    input  logic                        rd_req_snap,
    output logic                        rd_rsp_valid,
    input  logic                        rd_rsp_ready,
    output logic [CNT_W-1:0]            rd_rsp_data,
    output logic                        rd_rsp_err,
    input  logic                        dump_start,
    output logic                        dump_busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [IDX_W-1:0]            out_idx,
    output logic [CNT_W-1:0]            out_data,
    output logic                        out_last
);

    // IDX_W must satisfy 2**IDX_W >= NUM_CNT
    localparam int unsigned NUM_CNT = perf_num_cnt(NUM_EVENTS);
    localparam int unsigned BANK_W  = NUM_CNT * CNT_W;

    // ------------------------------------------------------------------
    // Bank views
    // ------------------------------------------------------------------
    logic [BANK_W-1:0] live_bank;
    logic [BANK_W-1:0] rd_src_bank;

    // Concatenation order places cycle at index 0, instret at 1, events from 2
    assign live_bank   = {event_counts, instret_count, cycle_count};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]        state_q,       state_d;
    logic [BANK_W-1:0] snap_q,        snap_d;
    logic [IDX_W-1:0]  out_idx_q,     out_idx_d;
    logic [CNT_W-1:0]  out_data_q,    out_data_d;
    logic              out_last_q,    out_last_d;
    logic              rd_rsp_valid_q, rd_rsp_valid_d;
    logic [CNT_W-1:0]  rd_rsp_data_q, rd_rsp_data_d;
    logic              rd_rsp_err_q,  rd_rsp_err_d;

    // ------------------------------------------------------------------
    // Counter selects
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  rd_data_c;
    logic              rd_err_c;
    logic [IDX_W-1:0]  out_idx_nxt_c;
    logic [CNT_W-1:0]  strm_data_c;
    logic              strm_err_c;

    // Snapshot reads see snap_q, i.e. the value before any capture on this edge
    assign rd_src_bank   = rd_req_snap ? snap_q : live_bank;
    assign out_idx_nxt_c = out_idx_q + IDX_W'(1);

    // Read port source: live or snapshot copy
    perf_cnt_mux #(
        .NUM_CNT (NUM_CNT),
        .CNT_W   (CNT_W),
        .IDX_W   (IDX_W)
    ) u_rd_mux (
        .bank    (rd_src_bank),
        .idx     (rd_req_idx),
        .data_c  (rd_data_c),
        .err_c   (rd_err_c)
    );

    // Stream source: always the snapshot, looked up one beat ahead
    perf_cnt_mux #(
        .NUM_CNT (NUM_CNT),
        .CNT_W   (CNT_W),
        .IDX_W   (IDX_W)
    ) u_strm_mux (
        .bank    (snap_q),
        .idx     (out_idx_nxt_c),
        .data_c  (strm_data_c),
        .err_c   (strm_err_c)
    );

    // ------------------------------------------------------------------
    // Dump FSM: capture on start, stream with beats pre-registered
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        out_idx_d  = out_idx_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;

        if (state_q == DUMP_IDLE) begin
            if (dump_start) begin
                state_d    = DUMP_STREAM;
                snap_d     = live_bank;
                out_idx_d  = IDX_W'(PERF_IDX_CYCLE);
                // First beat comes straight from the live bank being captured
                out_data_d = live_bank[PERF_IDX_CYCLE*CNT_W +: CNT_W];
                out_last_d = (NUM_CNT == 1);
            end
        end else begin
            // dump_start is ignored here; only the consumer advances the stream
            if (out_ready) begin
                if (out_last_q) begin
                    state_d    = DUMP_IDLE;
                    out_idx_d  = '0;
                    out_data_d = '0;
                    out_last_d = 1'b0;
                end else begin
                    out_idx_d  = out_idx_nxt_c;
                    out_data_d = strm_err_c ? '0 : strm_data_c;
                    out_last_d = (out_idx_nxt_c == IDX_W'(NUM_CNT - 1));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port: single response slot, refilled on the consuming cycle
    // ------------------------------------------------------------------
    assign rd_req_ready = !rd_rsp_valid_q || rd_rsp_ready;

    always_comb begin
        rd_rsp_valid_d = rd_rsp_valid_q;
        rd_rsp_data_d  = rd_rsp_data_q;
        rd_rsp_err_d   = rd_rsp_err_q;

        if (rd_req_valid && rd_req_ready) begin
            rd_rsp_valid_d = 1'b1;
            rd_rsp_data_d  = rd_data_c;
            rd_rsp_err_d   = rd_err_c;
        end else if (rd_rsp_ready) begin
            rd_rsp_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= DUMP_IDLE;
            snap_q         <= '0;
            out_idx_q      <= '0;
            out_data_q     <= '0;
            out_last_q     <= 1'b0;
            rd_rsp_valid_q <= 1'b0;
            rd_rsp_data_q  <= '0;
            rd_rsp_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            snap_q         <= snap_d;
            out_idx_q      <= out_idx_d;
            out_data_q     <= out_data_d;
            out_last_q     <= out_last_d;
            rd_rsp_valid_q <= rd_rsp_valid_d;
            rd_rsp_data_q  <= rd_rsp_data_d;
            rd_rsp_err_q   <= rd_rsp_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign dump_busy    = (state_q == DUMP_STREAM);
    assign out_valid    = (state_q == DUMP_STREAM);
    assign out_idx      = out_idx_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign rd_rsp_valid = rd_rsp_valid_q;
    assign rd_rsp_data  = rd_rsp_data_q;
    assign rd_rsp_err   = rd_rsp_err_q;

endmodule : perf_counter_reader

// File: tb/tb_perf_counter_reader.sv
// ---------------------------------------------------------------------------
// tb_perf_counter_reader
// Directed bench for perf_counter_reader: full dumps with and without
// backpressure, live/snapshot reads, out-of-range reads, ignored restart,
// reset mid-dump and response-slot backpressure.
// ---------------------------------------------------------------------------
module tb_perf_counter_reader;

    localparam int unsigned NUM_EVENTS = 32;
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned NUM_CNT    = NUM_EVENTS + 2;

    logic                        clk;
    logic                        reset;
    logic [CNT_W-1:0]            cycle_count;
    logic [CNT_W-1:0]            instret_count;
    logic [NUM_EVENTS*CNT_W-1:0] event_counts;
    logic                        rd_req_valid;
    logic                        rd_req_ready;
    logic [IDX_W-1:0]            rd_req_idx;
    logic                        rd_req_snap;
    logic                        rd_rsp_valid;
    logic                        rd_rsp_ready;
    logic [CNT_W-1:0]            rd_rsp_data;
    logic                        rd_rsp_err;
    logic                        dump_start;
    logic                        dump_busy;
    logic                        out_valid;
    logic                        out_ready;
    logic [IDX_W-1:0]            out_idx;
    logic [CNT_W-1:0]            out_data;
    logic                        out_last;

    int unsigned n_checks;
    int unsigned n_fail;

    perf_counter_reader #(
        .NUM_EVENTS (NUM_EVENTS),
        .CNT_W      (CNT_W),
        .IDX_W      (IDX_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cycle_count   (cycle_count),
        .instret_count (instret_count),
        .event_counts  (event_counts),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_idx    (rd_req_idx),
        .rd_req_snap   (rd_req_snap),
        .rd_rsp_valid  (rd_rsp_valid),
        .rd_rsp_ready  (rd_rsp_ready),
        .rd_rsp_data   (rd_rsp_data),
        .rd_rsp_err    (rd_rsp_err),
        .dump_start    (dump_start),
        .dump_busy     (dump_busy),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_idx       (out_idx),
        .out_data      (out_data),
        .out_last      (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Step past the next rising edge; outputs are stable when this returns
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive live counters: cycle, instret, event i = base + step*i
    task automatic set_cnt(input int unsigned cyc, input int unsigned ins,
                           input int unsigned base, input int unsigned step);
        cycle_count   = CNT_W'(cyc);
        instret_count = CNT_W'(ins);
        for (int i = 0; i < int'(NUM_EVENTS); i++)
            event_counts[i*CNT_W +: CNT_W] = CNT_W'(base + step * i);
    endtask

    function automatic logic [CNT_W-1:0] exp_val(input int unsigned idx, input int unsigned cyc,
                                                 input int unsigned ins, input int unsigned base,
                                                 input int unsigned step);
        if (idx == 0) return CNT_W'(cyc);
        if (idx == 1) return CNT_W'(ins);
        return CNT_W'(base + step * (idx - 2));
    endfunction

    task automatic pulse_dump();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
    endtask

    // Let any active dump finish with the consumer always ready
    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int n = 0; n < 100 && dump_busy; n++) tick();
        check_eq(tag, dump_busy, 1'b0);
    endtask

    initial begin
        int unsigned exp_idx;
        logic        done;
        logic        rdy;

        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        rd_req_valid  = 1'b0;
        rd_req_idx    = '0;
        rd_req_snap   = 1'b0;
        rd_rsp_ready  = 1'b1;
        dump_start    = 1'b0;
        out_ready     = 1'b0;
        set_cnt(100, 50, 0, 3);
        tick();
        tick();

        // Reset state
        check_eq("rst_busy",     dump_busy,    1'b0);
        check_eq("rst_valid",    out_valid,    1'b0);
        check_eq("rst_idx",      out_idx,      0);
        check_eq("rst_data",     out_data,     0);
        check_eq("rst_last",     out_last,     1'b0);
        check_eq("rst_rsp_vld",  rd_rsp_valid, 1'b0);
        check_eq("rst_rsp_data", rd_rsp_data,  0);
        check_eq("rst_rsp_err",  rd_rsp_err,   1'b0);
        check_eq("rst_req_rdy",  rd_req_ready, 1'b1);
        reset = 1'b0;
        tick();

        // 1: full dump of static counters, consumer always ready
        out_ready = 1'b1;
        pulse_dump();
        for (int b = 0; b < int'(NUM_CNT); b++) begin
            check_eq("t1_busy",  dump_busy, 1'b1);
            check_eq("t1_valid", out_valid, 1'b1);
            check_eq("t1_idx",   out_idx,   b);
            check_eq("t1_data",  out_data,  exp_val(b, 100, 50, 0, 3));
            check_eq("t1_last",  out_last,  (b == int'(NUM_CNT) - 1));
            tick();
        end
        check_eq("t1_busy_end",  dump_busy, 1'b0);
        check_eq("t1_valid_end", out_valid, 1'b0);

        // 2: ready toggling 1,0 while live counters move every cycle
        set_cnt(1000, 2000, 5, 10);
        pulse_dump();
        exp_idx = 0;
        done    = 1'b0;
        rdy     = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            check_eq("t2_valid", out_valid, 1'b1);
            check_eq("t2_idx",   out_idx,   exp_idx);
            check_eq("t2_data",  out_data,  exp_val(exp_idx, 1000, 2000, 5, 10));
            check_eq("t2_last",  out_last,  (exp_idx == NUM_CNT - 1));
            out_ready = rdy;
            set_cnt(1001 + n, 2001 + n, 6 + n, 10);
            tick();
            if (rdy) begin
                if (exp_idx == NUM_CNT - 1) done = 1'b1;
                exp_idx++;
            end
            rdy = !rdy;
        end
        check_eq("t2_done",      done,      1'b1);
        check_eq("t2_busy_end",  dump_busy, 1'b0);
        check_eq("t2_valid_end", out_valid, 1'b0);

        // 3: live read idx 3 (event1 = 7), then out-of-range idx 40 back-to-back
        set_cnt(0, 0, 0, 7);
        rd_rsp_ready = 1'b1;
        rd_req_valid = 1'b1;
        rd_req_snap  = 1'b0;
        rd_req_idx   = IDX_W'(3);
        tick();
        check_eq("t3_vld",  rd_rsp_valid, 1'b1);
        check_eq("t3_data", rd_rsp_data,  7);
        check_eq("t3_err",  rd_rsp_err,   1'b0);
        rd_req_idx = IDX_W'(40);
        tick();
        check_eq("t3_oor_vld",  rd_rsp_valid, 1'b1);
        check_eq("t3_oor_data", rd_rsp_data,  0);
        check_eq("t3_oor_err",  rd_rsp_err,   1'b1);
        rd_req_valid = 1'b0;
        tick();
        check_eq("t3_idle_vld", rd_rsp_valid, 1'b0);

        // 4: snapshot vs live after counters advance; snap read on capture edge
        set_cnt(100, 50, 0, 3);
        out_ready = 1'b1;
        pulse_dump();
        drain("t4_drain1");
        set_cnt(500, 60, 1, 1);
        rd_req_valid = 1'b1;
        rd_req_snap  = 1'b1;
        rd_req_idx   = IDX_W'(0);
        tick();
        check_eq("t4_snap", rd_rsp_data, 100);
        rd_req_snap = 1'b0;
        tick();
        check_eq("t4_live", rd_rsp_data, 500);
        rd_req_snap = 1'b1;
        dump_start  = 1'b1;
        tick();
        dump_start = 1'b0;
        check_eq("t4_snap_same_edge", rd_rsp_data, 100);
        tick();
        check_eq("t4_snap_new", rd_rsp_data, 500);
        rd_req_valid = 1'b0;
        rd_req_snap  = 1'b0;
        drain("t4_drain2");

        // 5: restart ignored at beat 5, reset at beat 10, fresh dump afterwards
        set_cnt(100, 50, 0, 3);
        out_ready = 1'b1;
        pulse_dump();
        for (int b = 0; b < 10; b++) begin
            check_eq("t5_idx",  out_idx,  b);
            check_eq("t5_data", out_data, exp_val(b, 100, 50, 0, 3));
            if (b == 5) begin
                dump_start = 1'b1;
                set_cnt(9999, 9999, 1, 1);
            end else begin
                dump_start = 1'b0;
            end
            tick();
        end
        dump_start = 1'b0;
        check_eq("t5_idx10",  out_idx,  10);
        check_eq("t5_data10", out_data, exp_val(10, 100, 50, 0, 3));
        #2;
        reset = 1'b1;
        #1;
        check_eq("t5_rst_valid", out_valid, 1'b0);
        check_eq("t5_rst_busy",  dump_busy, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        set_cnt(4242, 77, 2, 5);
        pulse_dump();
        check_eq("t5_re_busy", dump_busy, 1'b1);
        check_eq("t5_re_idx",  out_idx,   0);
        check_eq("t5_re_data", out_data,  4242);
        tick();
        check_eq("t5_re_idx1",  out_idx,  1);
        check_eq("t5_re_data1", out_data, 77);
        drain("t5_drain");

        // 6: response slot held under backpressure; second request waits
        set_cnt(10, 20, 30, 1);
        rd_rsp_ready = 1'b0;
        rd_req_valid = 1'b1;
        rd_req_snap  = 1'b0;
        rd_req_idx   = IDX_W'(1);
        tick();
        check_eq("t6_vld1",  rd_rsp_valid, 1'b1);
        check_eq("t6_data1", rd_rsp_data,  20);
        rd_req_idx = IDX_W'(2);
        set_cnt(11, 21, 31, 1);
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("t6_req_rdy", rd_req_ready, 1'b0);
            check_eq("t6_hold_v",  rd_rsp_valid, 1'b1);
            check_eq("t6_hold_d",  rd_rsp_data,  20);
            tick();
        end
        rd_rsp_ready = 1'b1;
        #1;
        check_eq("t6_req_rdy1", rd_req_ready, 1'b1);
        tick();
        rd_req_valid = 1'b0;
        check_eq("t6_vld2",  rd_rsp_valid, 1'b1);
        check_eq("t6_data2", rd_rsp_data,  31);
        check_eq("t6_err2",  rd_rsp_err,   1'b0);
        tick();
        check_eq("t6_vld_end", rd_rsp_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_perf_counter_reader
